// File: rtl/sha_padder_mw.sv
// sha_padder_mw: packs a byte stream into SHA-224/256 (512b) or SHA-384/512
// (1024b) blocks, appending the 0x80 marker, zero fill and big-endian bit length.
`timescale 1ns/1ps
module sha_padder_mw #(
  parameter int  IN_BYTES = 4,
  parameter int  CNT_W    = 128,
  localparam int NB_W     = $clog2(IN_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*IN_BYTES-1:0] in_data,
  input  logic [NB_W-1:0]       in_nbytes,
  input  logic                  in_last,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [1023:0]         blk_data,
  output logic                  blk_mode,
  output logic                  blk_last,
  output logic [CNT_W-1:0]      bitlen
);

  // IDLE first beat | FILL accept beats | EMIT hold block | PAD1 0x80+len block | PAD2 zero+len block
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EMIT, S_PAD1, S_PAD2} state_t;

  state_t             state_q, after_q;
  logic [127:0][7:0]  buf_q, buf_d;
  logic [7:0]         r_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mode_q, valid_q, last_q, in_ready_q;

  logic               md, beat, pad_en, len_en;
  logic [7:0]         blk_b, blk_l, r_after, zstart, mpos;
  logic [CNT_W-1:0]   cnt_raw, cnt_sum, len_val;

  assign in_ready  = in_ready_q;
  assign blk_valid = valid_q;
  assign blk_mode  = mode_q;
  assign blk_last  = last_q;
  assign bitlen    = cnt_q;
  // Byte 0 always sits at the top of the buffer; mode 0 shifts the 64-byte view down.
  assign blk_data  = mode_q ? buf_q : {512'd0, buf_q[127:64]};

  always_comb begin
    md      = (state_q == S_IDLE) ? mode : mode_q;
    beat    = in_valid && in_ready_q;
    blk_b   = md ? 8'd128 : 8'd64;
    blk_l   = md ? 8'd16  : 8'd8;
    r_after = r_q + 8'(in_nbytes);
    cnt_raw = cnt_q + CNT_W'({in_nbytes, 3'b000});
    cnt_sum = md ? cnt_raw : {{(CNT_W-64){1'b0}}, cnt_raw[63:0]};
    pad_en  = 1'b0;
    len_en  = 1'b0;
    zstart  = 8'd0;
    mpos    = blk_b;
    len_val = cnt_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (beat && in_last) begin
          pad_en  = (r_after < blk_b);
          len_en  = (r_after < blk_b - blk_l);
          zstart  = r_after;
          mpos    = r_after;
          len_val = cnt_sum;
        end
      end
      S_PAD1: begin
        pad_en = 1'b1;
        len_en = 1'b1;
        mpos   = 8'd0;
      end
      S_PAD2: begin
        pad_en = 1'b1;
        len_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [7:0] idx;
    logic [7:0] d;
    idx   = '0;
    d     = '0;
    buf_d = buf_q;
    if (state_q == S_IDLE || state_q == S_FILL) begin
      for (int k = 0; k < IN_BYTES; k++) begin
        idx = r_q + 8'(k);
        if (NB_W'(k) < in_nbytes && idx < 8'd128)
          buf_d[7'(8'd127 - idx)] = in_data[8*(IN_BYTES-1-k) +: 8];
      end
    end
    if (pad_en) begin
      for (int j = 0; j < 128; j++) begin
        if (8'(j) < blk_b) begin
          if (8'(j) == mpos)
            buf_d[7'(127 - j)] = 8'h80;
          else if (8'(j) >= zstart)
            buf_d[7'(127 - j)] = 8'h00;
          if (len_en && 8'(j) >= blk_b - blk_l) begin
            d = blk_b - 8'd1 - 8'(j);
            buf_d[7'(127 - j)] = 8'(len_val >> {d, 3'b000});
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      after_q    <= S_FILL;
      buf_q      <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FILL: begin
          in_ready_q <= 1'b1;
          if (beat) begin
            if (state_q == S_IDLE) mode_q <= mode;
            buf_q   <= buf_d;
            cnt_q   <= cnt_sum;
            r_q     <= r_after;
            state_q <= S_FILL;
            if (in_last || r_after == blk_b) begin
              state_q    <= S_EMIT;
              valid_q    <= 1'b1;
              in_ready_q <= 1'b0;
              last_q     <= in_last && (r_after < blk_b - blk_l);
              if (!in_last)                    after_q <= S_FILL;
              else if (r_after < blk_b - blk_l) after_q <= S_IDLE;
              else if (r_after < blk_b)         after_q <= S_PAD2;
              else                              after_q <= S_PAD1;
            end
          end
        end
        S_EMIT: begin
          if (blk_ready) begin
            valid_q <= 1'b0;
            r_q     <= '0;
            state_q <= after_q;
            if (after_q == S_IDLE || after_q == S_FILL) in_ready_q <= 1'b1;
            if (last_q) begin
              cnt_q  <= '0;
              last_q <= 1'b0;
            end
          end
        end
        S_PAD1, S_PAD2: begin
          buf_q   <= buf_d;
          valid_q <= 1'b1;
          last_q  <= 1'b1;
          after_q <= S_IDLE;
          state_q <= S_EMIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_padder_mw.sv
// Scoreboard bench for sha_padder_mw: stimulus pushes expected blocks, a
// negedge monitor pops and compares each transferred block.
`timescale 1ns/1ps
module tb_sha_padder_mw;
  localparam int IN_BYTES = 4;
  localparam int NB_W     = $clog2(IN_BYTES + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mode = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [8*IN_BYTES-1:0] in_data = '0;
  logic [NB_W-1:0]       in_nbytes = '0;
  logic                  in_last = 1'b0;
  logic                  blk_valid;
  logic                  blk_ready = 1'b1;
  logic [1023:0]         blk_data;
  logic                  blk_mode;
  logic                  blk_last;
  logic [127:0]          bitlen;

  typedef struct {
    logic [1023:0] data;
    logic          last;
    logic          md;
    logic [127:0]  blen;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] msg [256];
  int         n_vec = 0;
  int         n_err = 0;
  bit         bp_en = 0;
  int         hold_cnt = 0;

  always #5 clk = ~clk;

  sha_padder_mw #(.IN_BYTES(IN_BYTES), .CNT_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_nbytes(in_nbytes), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_mode(blk_mode), .blk_last(blk_last), .bitlen(bitlen)
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    int bi;
    n_vec++;
    if (got !== exp) begin
      n_err++;
      bi = 0;
      for (int b = 127; b >= 0; b--) begin
        if (got[8*b +: 8] !== exp[8*b +: 8]) begin
          bi = b;
          break;
        end
      end
      $display("FAIL %s: bits [%0d:%0d] got %02h expected %02h",
               nm, 8*bi+7, 8*bi, got[8*bi +: 8], exp[8*bi +: 8]);
    end
  endtask

  task automatic push_hand(input logic [1023:0] d, input logic l, input logic md,
                           input logic [127:0] blen);
    exp_t x;
    x.data = d; x.last = l; x.md = md; x.blen = blen;
    exp_q.push_back(x);
  endtask

  // Reference padding: message || 0x80 || zeros || length, cut into blocks.
  task automatic push_model(input bit md, input int n, input logic [127:0] blen);
    int bb, ll, total, nb, top;
    logic [7:0] pm [256];
    exp_t x;
    bb = md ? 128 : 64;
    ll = md ? 16 : 8;
    top = md ? 1023 : 511;
    total = ((n + 1 + ll + bb - 1) / bb) * bb;
    for (int i = 0; i < total; i++)
      pm[i] = (i < n) ? msg[i] : ((i == n) ? 8'h80 : 8'h00);
    for (int d = 0; d < ll; d++) pm[total-1-d] = blen[8*d +: 8];
    nb = total / bb;
    for (int b = 0; b < nb; b++) begin
      x.data = '0;
      for (int i = 0; i < bb; i++) x.data[top - 8*i -: 8] = pm[b*bb + i];
      x.last = (b == nb - 1);
      x.md   = md;
      x.blen = blen;
      exp_q.push_back(x);
    end
  endtask

  task automatic send_beat(input logic [8*IN_BYTES-1:0] d, input logic [NB_W-1:0] nb,
                           input logic l);
    int  guard = 0;
    bit  acc = 0;
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = l;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 2000) begin
        n_vec++; n_err++;
        $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input bit md, input int n, input bit fin);
    int i = 0;
    int k;
    logic [8*IN_BYTES-1:0] d;
    mode = md;
    if (n == 0) send_beat({IN_BYTES{8'hEE}}, '0, 1'b1);
    while (i < n) begin
      k = (n - i < IN_BYTES) ? n - i : IN_BYTES;
      d = {IN_BYTES{8'hEE}};
      for (int b = 0; b < k; b++) d[8*(IN_BYTES-1-b) +: 8] = msg[i+b];
      send_beat(d, NB_W'(k), fin && (i + k == n));
      mode = ~md;
      i += k;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d blocks pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  task automatic fill_msg(input int seed);
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 13 + seed);
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      if (!bp_en) begin
        blk_ready = 1'b1;
        hold_cnt  = 0;
      end else if (!blk_valid) blk_ready = 1'b0;
      else if (hold_cnt >= 5) begin
        blk_ready = 1'b1;
        hold_cnt  = 0;
      end else begin
        blk_ready = 1'b0;
        hold_cnt++;
      end
    end
  end

  logic [1023:0] prev_data;
  logic          prev_last;
  logic [127:0]  prev_bl;
  bit            prev_ok = 0;
  bit            want_rdy = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok  = 0;
      want_rdy = 0;
    end else begin
      if (want_rdy) begin
        chk("in_ready_after_last", 128'(in_ready), 128'd1);
        want_rdy = 0;
      end
      if (blk_valid && !blk_ready) begin
        chk("in_ready_stall", 128'(in_ready), 128'd0);
        if (prev_ok) begin
          chk_data("stall_data", blk_data, prev_data);
          chk("stall_last", 128'(blk_last), 128'(prev_last));
          chk("stall_bitlen", bitlen, prev_bl);
        end
        prev_data = blk_data;
        prev_last = blk_last;
        prev_bl   = bitlen;
        prev_ok   = 1;
      end else prev_ok = 0;
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_block: got a block, expected none");
        end else begin
          e = exp_q.pop_front();
          chk_data("blk_data", blk_data, e.data);
          chk("blk_last", 128'(blk_last), 128'(e.last));
          chk("blk_mode", 128'(blk_mode), 128'(e.md));
          chk("in_ready_busy", 128'(in_ready), 128'd0);
          if (e.last) chk("bitlen", bitlen, e.blen);
          want_rdy = e.last;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_blk_valid", 128'(blk_valid), 128'd0);
    chk("rst_blk_last", 128'(blk_last), 128'd0);
    chk("rst_blk_mode", 128'(blk_mode), 128'd0);
    chk("rst_bitlen", bitlen, 128'd0);
    chk_data("rst_blk_data", blk_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 128'(in_ready), 128'd1);

    load_abc();
    push_hand({512'd0, 32'h61626380, 416'd0, 64'h18}, 1'b1, 1'b0, 128'd24);
    send_msg(0, 3, 1);
    drain();

    push_hand({512'd0, 8'h80, 504'd0}, 1'b1, 1'b0, 128'd0);
    send_msg(0, 0, 1);
    push_hand({8'h80, 1016'd0}, 1'b1, 1'b1, 128'd0);
    send_msg(1, 0, 1);
    drain();

    fill_msg(5);
    push_model(0, 55, 128'h1B8);  send_msg(0, 55, 1);
    push_model(0, 56, 128'h1C0);  send_msg(0, 56, 1);
    push_model(1, 111, 128'h378); send_msg(1, 111, 1);
    push_model(1, 112, 128'h380); send_msg(1, 112, 1);
    push_model(0, 64, 128'h200);  send_msg(0, 64, 1);
    drain();

    fill_msg(77);
    bp_en = 1;
    push_model(1, 200, 128'd1600);
    send_msg(1, 200, 1);
    drain();
    bp_en = 0;

    fill_msg(200);
    send_msg(0, 20, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_blk_valid", 128'(blk_valid), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    chk("midrst_bitlen", bitlen, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_abc();
    push_hand({512'd0, 32'h61626380, 416'd0, 64'h18}, 1'b1, 1'b0, 128'd24);
    send_msg(0, 3, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
